// File: rtl/dmi_jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module.
package debug_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } onebit_sig_e;

    localparam int DMI_ABITS     = 7;
    localparam int DMI_DATA_BITS = 32;
    localparam int DMI_REG_BITS  = DMI_ABITS + DMI_DATA_BITS + 2;

    // Debug module register map (subset); other addresses are reached by cast.
    typedef enum logic [DMI_ABITS-1:0] {
        DM_DATA0      = 7'h04,
        DM_DATA1      = 7'h05,
        DM_DMCONTROL  = 7'h10,
        DM_DMSTATUS   = 7'h11,
        DM_HARTINFO   = 7'h12,
        DM_ABSTRACTCS = 7'h16,
        DM_COMMAND    = 7'h17,
        DM_SBCS       = 7'h38
    } dm_addresses_e;

    typedef enum logic [3:0] {
        TAP_TEST_LOGIC_RESET,
        TAP_RUN_TEST_IDLE,
        TAP_SELECT_DR_SCAN,
        TAP_CAPTURE_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPDATE_DR,
        TAP_SELECT_IR_SCAN,
        TAP_CAPTURE_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPDATE_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_ISSUE,
        REQ_WAIT
    } req_state_e;

    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_BYPASS  = 5'h1F;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMISTAT_OK   = 2'd0;
    localparam logic [1:0] DMISTAT_BUSY = 2'd3;

    localparam logic [3:0] DTMCS_VERSION = 4'd1;

    // Index of the bit where TDI enters the shift register for the selected DR.
    function automatic logic [5:0] dr_msb(input logic [4:0] ir);
        case (ir)
            IR_IDCODE, IR_DTMCS: dr_msb = 6'd31;
            IR_DMI:              dr_msb = 6'(DMI_REG_BITS - 1);
            default:             dr_msb = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmi_jtag_dtm_tap.sv
// IEEE 1149.1 TAP controller advanced by oversampled TCK strobes.
module jtag_tap_fsm
    import debug_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tck_rise,
    input  logic       tck_fall,
    input  logic       tms,
    output tap_state_e state,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e next_state;

    // Standard 16-state TAP transition table driven by TMS.
    always_comb begin
        next_state = state;
        unique case (state)
            TAP_TEST_LOGIC_RESET: next_state = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    next_state = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR_SCAN:   next_state = tms ? TAP_SELECT_IR_SCAN   : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       next_state = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         next_state = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         next_state = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         next_state = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         next_state = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        next_state = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR_SCAN:   next_state = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       next_state = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         next_state = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         next_state = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         next_state = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         next_state = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        next_state = tms ? TAP_SELECT_DR_SCAN   : TAP_RUN_TEST_IDLE;
            default:              next_state = TAP_TEST_LOGIC_RESET;
        endcase
    end

    // State register; moves only on a rising TCK strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= TAP_TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            state <= next_state;
        end
    end

    // Capture and shift act on the rising edge leaving the state, update on the falling edge inside it.
    assign capture_ir = tck_rise && (state == TAP_CAPTURE_IR);
    assign shift_ir   = tck_rise && (state == TAP_SHIFT_IR);
    assign update_ir  = tck_fall && (state == TAP_UPDATE_IR);
    assign capture_dr = tck_rise && (state == TAP_CAPTURE_DR);
    assign shift_dr   = tck_rise && (state == TAP_SHIFT_DR);
    assign update_dr  = tck_fall && (state == TAP_UPDATE_DR);

endmodule

// File: rtl/dmi_jtag_dtm.sv
// JTAG DTM: oversampled TAP, IR/DR shift logic, DTMCS/DMI registers and DMI request FSM.
module dmi_jtag_dtm
    import debug_pkg::*;
#(
    parameter logic [31:0] IDCODE    = 32'h1000_0001,
    parameter logic [2:0]  IDLE_HINT = 3'd5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tck_i,
    input  logic          tms_i,
    input  logic          tdi_i,
    output logic          tdo_o,
    output logic          tdo_oe_o,
    output onebit_sig_e   dmi_wr_o,
    output onebit_sig_e   dmi_rd_o,
    output dm_addresses_e dmi_ad_o,
    output logic [31:0]   dmi_do_o,
    input  logic [31:0]   dmi_di_i
);

    logic tck_meta, tck_sync, tck_prev;
    logic tms_meta, tms_sync, tms_q;
    logic tdi_meta, tdi_sync, tdi_q;
    logic tck_rise, tck_fall;

    tap_state_e tap_state;
    logic capture_ir, shift_ir, update_ir;
    logic capture_dr, shift_dr, update_dr;
    logic tap_reset, in_shift;

    logic [4:0]                  ir;
    logic [DMI_REG_BITS-1:0]     sr;
    logic [DMI_REG_BITS-1:0]     dr_capture;
    logic [DMI_REG_BITS-1:0]     dr_shifted;
    logic [31:0]                 dtmcs_value;

    req_state_e                  req_state;
    logic                        req_is_read;
    logic [1:0]                  dmistat;
    logic [DMI_DATA_BITS-1:0]    rdata;
    logic [DMI_ABITS-1:0]        last_addr;
    logic [1:0]                  scan_op;
    logic                        dtmcs_update, dmi_update, hard_reset;

    // Two-flop synchronisers plus a registered edge detector on TCK; TMS/TDI are delayed to stay aligned with the strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tck_meta <= 1'b0;
            tck_sync <= 1'b0;
            tck_prev <= 1'b0;
            tms_meta <= 1'b0;
            tms_sync <= 1'b0;
            tms_q    <= 1'b0;
            tdi_meta <= 1'b0;
            tdi_sync <= 1'b0;
            tdi_q    <= 1'b0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
        end else begin
            tck_meta <= tck_i;
            tck_sync <= tck_meta;
            tck_prev <= tck_sync;
            tms_meta <= tms_i;
            tms_sync <= tms_meta;
            tms_q    <= tms_sync;
            tdi_meta <= tdi_i;
            tdi_sync <= tdi_meta;
            tdi_q    <= tdi_sync;
            tck_rise <= tck_sync & ~tck_prev;
            tck_fall <= ~tck_sync & tck_prev;
        end
    end

    jtag_tap_fsm u_tap (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tck_rise   (tck_rise),
        .tck_fall   (tck_fall),
        .tms        (tms_q),
        .state      (tap_state),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tap_reset = (tap_state == TAP_TEST_LOGIC_RESET);
    assign in_shift  = (tap_state == TAP_SHIFT_DR) || (tap_state == TAP_SHIFT_IR);

    assign dtmcs_value = {14'd0, 1'b0, 1'b0, 1'b0, IDLE_HINT, dmistat, 6'(DMI_ABITS), DTMCS_VERSION};

    // Parallel value loaded into the shift register at Capture-DR for the selected register.
    always_comb begin
        dr_capture = '0;
        case (ir)
            IR_IDCODE: dr_capture = {9'd0, IDCODE};
            IR_DTMCS:  dr_capture = {9'd0, dtmcs_value};
            IR_DMI:    dr_capture = {last_addr, rdata, dmistat};
            default:   dr_capture = '0;
        endcase
    end

    // One DR shift step: TDI enters at the top bit of the currently selected register.
    always_comb begin
        dr_shifted = sr >> 1;
        dr_shifted[dr_msb(ir)] = tdi_q;
    end

    // Instruction register and the shared 41-bit shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir <= IR_IDCODE;
            sr <= '0;
        end else if (tap_reset) begin
            ir <= IR_IDCODE;
            sr <= '0;
        end else begin
            if (capture_ir) begin
                sr <= {36'd0, IR_CAPTURE};
            end else if (shift_ir) begin
                sr[4:0] <= {tdi_q, sr[4:1]};
            end else if (capture_dr) begin
                sr <= dr_capture;
            end else if (shift_dr) begin
                sr <= dr_shifted;
            end
            if (update_ir) begin
                ir <= sr[4:0];
            end
        end
    end

    assign scan_op      = sr[1:0];
    assign dtmcs_update = update_dr && (ir == IR_DTMCS);
    assign dmi_update   = update_dr && (ir == IR_DMI);
    assign hard_reset   = dtmcs_update && sr[17];

    // Request FSM with sticky status: turns a DMI Update-DR into a one-cycle request and collects read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_state   <= REQ_IDLE;
            req_is_read <= 1'b0;
            dmi_wr_o    <= FALSE;
            dmi_rd_o    <= FALSE;
            dmi_ad_o    <= dm_addresses_e'(7'd0);
            dmi_do_o    <= '0;
            rdata       <= '0;
            dmistat     <= DMISTAT_OK;
            last_addr   <= '0;
        end else begin
            dmi_wr_o <= FALSE;
            dmi_rd_o <= FALSE;

            unique case (req_state)
                REQ_ISSUE: req_state <= REQ_WAIT;
                REQ_WAIT: begin
                    if (req_is_read && !hard_reset) begin
                        rdata <= dmi_di_i;
                    end
                    req_state <= REQ_IDLE;
                end
                default: req_state <= REQ_IDLE;
            endcase

            if (tap_reset) begin
                dmistat <= DMISTAT_OK;
            end else if (dtmcs_update) begin
                if (sr[17]) begin
                    dmistat   <= DMISTAT_OK;
                    req_state <= REQ_IDLE;
                end else if (sr[16]) begin
                    dmistat <= DMISTAT_OK;
                end
            end else if (dmi_update && (scan_op != DMI_OP_NOP) && (dmistat == DMISTAT_OK)) begin
                if (req_state != REQ_IDLE) begin
                    dmistat <= DMISTAT_BUSY;
                end else if ((scan_op == DMI_OP_READ) || (scan_op == DMI_OP_WRITE)) begin
                    req_state   <= REQ_ISSUE;
                    req_is_read <= (scan_op == DMI_OP_READ);
                    dmi_wr_o    <= (scan_op == DMI_OP_WRITE) ? TRUE : FALSE;
                    dmi_rd_o    <= (scan_op == DMI_OP_READ) ? TRUE : FALSE;
                    dmi_ad_o    <= dm_addresses_e'(sr[40:34]);
                    dmi_do_o    <= sr[33:2];
                    last_addr   <= sr[40:34];
                end
            end
        end
    end

    // TDO changes on the falling TCK strobe so the probe samples it on the next rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else if (tck_fall) begin
            if (in_shift) begin
                tdo_o    <= sr[0];
                tdo_oe_o <= 1'b1;
            end else begin
                tdo_oe_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Self-checking bench for dmi_jtag_dtm: table-driven scans plus DMI request scoreboard.
module tb_dmi_jtag_dtm;
    import debug_pkg::*;

    localparam logic [31:0] RD_VALUE = 32'h0000_0382;

    typedef struct {
        logic [4:0]  ir;
        int          len;
        logic [40:0] din;
        logic [40:0] dout;
        bit          req;
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic          clk;
    logic          rst;
    logic          tck, tms, tdi;
    logic          tdo, tdo_oe;
    onebit_sig_e   dmi_wr, dmi_rd;
    dm_addresses_e dmi_ad;
    logic [31:0]   dmi_do;
    logic [31:0]   dmi_di;

    int   checks = 0;
    int   fails  = 0;
    txn_t expq[$];
    bit   prev_pulse = 1'b0;
    bit   rd_prev = 1'b0;
    vec_t vecs[12];

    dmi_jtag_dtm dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tck_i    (tck),
        .tms_i    (tms),
        .tdi_i    (tdi),
        .tdo_o    (tdo),
        .tdo_oe_o (tdo_oe),
        .dmi_wr_o (dmi_wr),
        .dmi_rd_o (dmi_rd),
        .dmi_ad_o (dmi_ad),
        .dmi_do_o (dmi_do),
        .dmi_di_i (dmi_di)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [40:0] actual, input logic [40:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Debug-module read responder: data appears the cycle after the read pulse.
    always @(negedge clk) begin
        dmi_di = rd_prev ? RD_VALUE : 32'hFFFF_FFFF;
        rd_prev = (dmi_rd === TRUE);
    end

    // Scoreboard: every request pulse is matched against the oldest expected transaction.
    always @(negedge clk) begin
        if (dmi_wr === TRUE || dmi_rd === TRUE) begin
            txn_t t;
            check_output("dmi_pulse_single_cycle", 41'(prev_pulse), 41'd0);
            check_output("dmi_wr_rd_exclusive", 41'(dmi_wr === TRUE && dmi_rd === TRUE), 41'd0);
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_dmi_request: got wr=%0d rd=%0d addr=0x%0h, expected none",
                         dmi_wr, dmi_rd, dmi_ad);
            end else begin
                t = expq.pop_front();
                check_output("dmi_req_wr", 41'(dmi_wr === TRUE), 41'(t.wr));
                check_output("dmi_req_rd", 41'(dmi_rd === TRUE), 41'(!t.wr));
                check_output("dmi_req_addr", 41'(dmi_ad), 41'(t.addr));
                check_output("dmi_req_data", 41'(dmi_do), 41'(t.data));
            end
        end
        prev_pulse = (dmi_wr === TRUE) || (dmi_rd === TRUE);
    end

    task automatic apply_stimulus(input logic tms_v, input logic tdi_v, output logic tdo_s, output logic oe_s);
        tms = tms_v;
        tdi = tdi_v;
        #30;
        tdo_s = tdo;
        oe_s  = tdo_oe;
        tck = 1'b1;
        #50;
        tck = 1'b0;
        #20;
    endtask

    task automatic shift_bits(input int len, input logic [40:0] din, output logic [40:0] dout, output logic oe_all);
        logic b, o;
        dout   = '0;
        oe_all = 1'b1;
        for (int i = 0; i < len; i++) begin
            apply_stimulus(i == len - 1, din[i], b, o);
            dout[i] = b;
            oe_all  = oe_all & o;
        end
    endtask

    task automatic tap_reset_seq();
        logic b, o;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
    endtask

    task automatic scan_ir(input logic [4:0] code);
        logic b, o, oe_all;
        logic [40:0] dout;
        apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        shift_bits(5, {36'd0, code}, dout, oe_all);
        check_output("ir_capture", dout, 41'(IR_CAPTURE));
        apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
    endtask

    task automatic scan_dr(input int len, input logic [40:0] din, input logic [40:0] exp_v,
                           input bit do_check, input string name, input bit go_idle);
        logic b, o, oe_all;
        logic [40:0] dout;
        apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        shift_bits(len, din, dout, oe_all);
        if (do_check) begin
            check_output(name, dout, exp_v);
            check_output({name, "_oe"}, 41'(oe_all), 41'd1);
        end
        apply_stimulus(1'b1, 1'b0, b, o);
        if (go_idle) apply_stimulus(1'b0, 1'b0, b, o);
    endtask

    function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    function automatic vec_t mk(input logic [4:0] ir, input int len, input logic [40:0] din, input logic [40:0] dout,
                                input bit req, input bit wr, input logic [6:0] addr, input logic [31:0] data);
        vec_t v;
        v.ir = ir; v.len = len; v.din = din; v.dout = dout;
        v.req = req; v.wr = wr; v.addr = addr; v.data = data;
        return v;
    endfunction

    initial begin
        logic b, o, seen;
        logic [40:0] dout;

        vecs[0]  = mk(IR_IDCODE, 32, 41'd0, 41'h0_1000_0001, 0, 0, 7'h00, 32'h0);
        vecs[1]  = mk(IR_DTMCS, 32, 41'd0, 41'h5071, 0, 0, 7'h00, 32'h0);
        vecs[2]  = mk(IR_DTMCS, 32, 41'd1 << 17, 41'h5071, 0, 0, 7'h00, 32'h0);
        vecs[3]  = mk(IR_DMI, 41, dmi_word(7'h04, 32'hDEAD_BEEF, 2'd2), 41'd0, 1, 1, 7'h04, 32'hDEAD_BEEF);
        vecs[4]  = mk(IR_DMI, 41, dmi_word(7'h11, 32'h0, 2'd1), dmi_word(7'h04, 32'h0, 2'd0), 1, 0, 7'h11, 32'h0);
        vecs[5]  = mk(IR_DMI, 41, dmi_word(7'h00, 32'h0, 2'd0), dmi_word(7'h11, RD_VALUE, 2'd0), 0, 0, 7'h00, 32'h0);
        vecs[6]  = mk(IR_DMI, 41, dmi_word(7'h22, 32'h1234_5678, 2'd3), dmi_word(7'h11, RD_VALUE, 2'd0), 0, 0, 7'h00, 32'h0);
        vecs[7]  = mk(IR_DMI, 41, dmi_word(7'h10, 32'hCAFE_0001, 2'd2), dmi_word(7'h11, RD_VALUE, 2'd0), 1, 1, 7'h10, 32'hCAFE_0001);
        vecs[8]  = mk(IR_DMI, 41, dmi_word(7'h00, 32'h0, 2'd0), dmi_word(7'h10, RD_VALUE, 2'd0), 0, 0, 7'h00, 32'h0);
        vecs[9]  = mk(IR_BYPASS, 9, 41'h0A5, 41'h14A, 0, 0, 7'h00, 32'h0);
        vecs[10] = mk(5'h05, 9, 41'h03C, 41'h078, 0, 0, 7'h00, 32'h0);
        vecs[11] = mk(5'h00, 9, 41'h1FF, 41'h1FE, 0, 0, 7'h00, 32'h0);

        rst = 1'b1;
        tck = 1'b0;
        tms = 1'b0;
        tdi = 1'b0;
        dmi_di = 32'h0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_output("reset_tdo", 41'(tdo), 41'd0);
        check_output("reset_tdo_oe", 41'(tdo_oe), 41'd0);
        check_output("reset_dmi_wr", 41'(dmi_wr), 41'd0);
        check_output("reset_dmi_rd", 41'(dmi_rd), 41'd0);
        check_output("reset_dmi_ad", 41'(dmi_ad), 41'd0);
        check_output("reset_dmi_do", 41'(dmi_do), 41'd0);

        apply_stimulus(1'b0, 1'b0, b, o);
        scan_dr(32, 41'd0, 41'h0_1000_0001, 1, "idcode_after_reset", 1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].req) begin
                expq.push_back('{wr: vecs[i].wr, addr: vecs[i].addr, data: vecs[i].data});
            end
            scan_ir(vecs[i].ir);
            scan_dr(vecs[i].len, vecs[i].din, vecs[i].dout, 1, $sformatf("vec%0d_dr", i), 1);
        end
        #60;
        check_output("oe_idle", 41'(tdo_oe), 41'd0);

        // Sticky busy status: visible in DTMCS and DMI captures, blocks requests, cleared by dmireset.
        force dut.dmistat = DMISTAT_BUSY;
        scan_ir(IR_DTMCS);
        scan_dr(32, 41'd0, 41'h5C71, 1, "dtmcs_busy", 1);
        scan_ir(IR_DMI);
        scan_dr(41, dmi_word(7'h05, 32'h5555_AAAA, 2'd2), dmi_word(7'h10, RD_VALUE, 2'd3), 1, "dmi_busy_capture", 1);
        release dut.dmistat;
        scan_ir(IR_DTMCS);
        scan_dr(32, 41'd1 << 16, 41'd0, 0, "dtmcs_dmireset", 1);
        scan_dr(32, 41'd0, 41'h5071, 1, "dtmcs_after_dmireset", 1);

        // TMS reset in the middle of a write scan: no request, IR back to IDCODE.
        scan_ir(IR_DMI);
        apply_stimulus(1'b1, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        apply_stimulus(1'b0, 1'b0, b, o);
        shift_bits(20, dmi_word(7'h04, 32'h1111_2222, 2'd2) >> 0, dout, o);
        tap_reset_seq();
        scan_dr(32, 41'd0, 41'h0_1000_0001, 1, "idcode_after_tms_reset", 1);

        // Async reset while the write pulse is high must drop it at once.
        scan_ir(IR_DMI);
        expq.push_back('{wr: 1'b1, addr: 7'h04, data: 32'hA5A5_0F0F});
        scan_dr(41, dmi_word(7'h04, 32'hA5A5_0F0F, 2'd2), dmi_word(7'h10, RD_VALUE, 2'd0), 1, "dmi_pre_rst_write", 0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dmi_wr === TRUE) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("wr_pulse_seen", 41'(seen), 41'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_drops_dmi_wr", 41'(dmi_wr), 41'd0);
        check_output("rst_clears_dmi_ad", 41'(dmi_ad), 41'd0);
        check_output("rst_clears_dmi_do", 41'(dmi_do), 41'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, b, o);
        scan_dr(32, 41'd0, 41'h0_1000_0001, 1, "idcode_after_rst", 1);

        repeat (20) @(negedge clk);
        check_output("expected_queue_drained", 41'(expq.size()), 41'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
